seg_display_mux: RTL and testbench
==================================

Name: seg_display_mux

Overview:
- Parametrised successor to the 4-digit hex display driver.
- Time-multiplexes NUM_DIGITS common-anode 7-segment digits from a shadowed hex value.
- Adds a load handshake, per-digit decimal points, PWM brightness and a per-digit scan strobe.
- Sits between the calculator datapath/PS2 result path and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- REFRESH_BITS, 18, width of the per-digit dwell counter; each digit is active for 2^REFRESH_BITS cycles. Must be >= BRIGHT_BITS.
- BRIGHT_BITS, 4, width of the brightness control.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  capture value/dp_mask into the shadow registers this edge
- value  in  4*NUM_DIGITS  hex nibbles; the top nibble is the leftmost digit
- dp_mask  in  NUM_DIGITS  decimal-point enables; bit i belongs to nibble i (bit 0 is the rightmost digit)
- brightness  in  BRIGHT_BITS  duty control, sampled live (not shadowed)
- anode  out  NUM_DIGITS  active-low digit enables; bit i drives the digit showing nibble i
- seg  out  7  active-low cathodes, gfedcba order (seg[0]=a)
- dp_n  out  1  active-low decimal point
- digit_strobe  out  1  one-cycle pulse when a new digit becomes active

Behaviour:
- Reset: clk and reset as above; polarity and synchronicity are fixed. Reset wins over load.
  - anode = all ones; seg = 7'h7F; dp_n = 1; digit_strobe = 0.
  - Shadow value and shadow dp_mask = 0; dwell counter = 0; scan index = NUM_DIGITS-1 (leftmost digit).
- Shadow capture: when load=1 at an edge, value and dp_mask are registered. Outputs use the new shadow data from the next edge onward, including mid-dwell of the current digit. When load=0 the shadow holds.
- Dwell counter: increments every cycle and wraps from 2^REFRESH_BITS-1 to 0.
  - On the wrap edge, the scan index steps down by 1.
  - From 0 the index wraps to NUM_DIGITS-1. The scan therefore runs left to right and covers every digit exactly once per frame.
- Outputs: all outputs are registered. The combinational decode of the current index, counter and shadow appears one cycle later.
  - digit_strobe is high in the same cycle that anode first shows the new index.
  - After reset, the first strobe and the first anode activation occur on the cycle following reset deassertion (index NUM_DIGITS-1, counter 0).
- Decode: the 16 hex glyphs use the standard active-low patterns, gfedcba order:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
- Decimal point: dp_n = ~shadow_dp[index].
- Brightness / PWM. Let phase = counter[REFRESH_BITS-1 -: BRIGHT_BITS].
  - brightness all ones: the digit is on for the whole dwell (100%).
  - Otherwise the digit is on only while phase < brightness.
  - brightness 0 keeps every anode high for the whole time.
  - While a digit is PWM-off, anode is all ones; seg and dp_n still carry the glyph.
- Exactly one anode bit is low at any time; none is low while blanked by PWM or in reset.
- Reset asserted mid-frame: the next edge returns all outputs to their reset values and restarts the scan at the leftmost digit.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Every digit to the left of the leftmost nonzero shadow nibble shows seg=7F.
  - The rightmost digit (nibble 0) is never blanked, so value 0 shows a single "0".
  - dp_n and anode timing are unaffected.
- Undefined: every digit shows its glyph, including leading zeros.

Test Plan (bench with NUM_DIGITS=4, REFRESH_BITS=4, BRIGHT_BITS=2):
- Reset then idle -> anode=1111, seg=7F, dp_n=1 during reset; the first post-reset cycle shows anode=0111, digit_strobe=1, seg=40.
- load with value=16'h1A3F, brightness=3 -> over one frame (64 cycles): anode 0111/1011/1101/1110 each for 16 cycles, with seg 79/08/30/0E; digit_strobe pulses 4 times, 16 cycles apart.
- dp_mask=4'b0100 loaded -> dp_n=0 only while anode=1011.
- brightness=1 -> each digit's anode is low for 4 of 16 cycles (phase 0); brightness=0 -> anode stays 1111 all frame while seg still cycles.
- Mid-dwell on digit 2: load value=16'hFFFF -> seg changes to 0E the second cycle after the load edge, with no extra strobe. Reset pulse mid-frame -> outputs go to reset values on the next edge and the scan restarts at 0111.
- SEG_LZ_BLANK_EN defined, value=16'h0040 -> seg sequence 7F,7F,19,40; value=16'h0000 -> 7F,7F,7F,40. Undefined -> 40,40,19,40.

Source files
------------

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadowed hex value, decimal points, PWM brightness, scan strobe.
// Define SEG_LZ_BLANK_EN to blank leading-zero digits (the rightmost digit is always shown).
module seg_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_BITS = 18,
  parameter int BRIGHT_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    digit_strobe
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]        IDX_LEFT = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REFRESH_BITS-1:0] CNT_MAX  = '1;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h7F;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // All-ones brightness means always on; otherwise on while the dwell phase is below it.
  function automatic logic pwm_on(input logic [BRIGHT_BITS-1:0] phase,
                                  input logic [BRIGHT_BITS-1:0] bright);
    return (&bright) || (phase < bright);
  endfunction

  // ---- Stage p0: shadow registers, dwell counter, scan index ----
  logic [4*NUM_DIGITS-1:0] shadow_val_p0;
  logic [NUM_DIGITS-1:0]   shadow_dp_p0;
  logic [REFRESH_BITS-1:0] cnt_p0;
  logic [IDX_W-1:0]        idx_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val_p0 <= '0;
      shadow_dp_p0  <= '0;
      cnt_p0        <= '0;
      idx_p0        <= IDX_LEFT;
    end else begin
      if (load) begin
        shadow_val_p0 <= value;
        shadow_dp_p0  <= dp_mask;
      end
      cnt_p0 <= cnt_p0 + 1'b1;
      if (cnt_p0 == CNT_MAX)
        idx_p0 <= (idx_p0 == '0) ? IDX_LEFT : idx_p0 - 1'b1;
    end
  end

  // ---- Decode of p0 state (combinational) ----
  logic [BRIGHT_BITS-1:0] phase_c;
  logic [3:0]             nib_c;
  logic                   blank_c;
  logic [NUM_DIGITS-1:0]  anode_c;

  assign phase_c = cnt_p0[REFRESH_BITS-1 -: BRIGHT_BITS];
  assign nib_c   = shadow_val_p0[idx_p0*4 +: 4];

`ifdef SEG_LZ_BLANK_EN
  // zero_run_c[i] is set when nibble i and every nibble left of it are zero.
  logic [NUM_DIGITS-1:0] zero_run_c;

  always_comb begin
    logic run;
    run        = 1'b1;
    zero_run_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run && (shadow_val_p0[4*i +: 4] == 4'h0);
      zero_run_c[i] = run;
    end
  end

  assign blank_c = (idx_p0 != '0) && zero_run_c[idx_p0];
`else
  assign blank_c = 1'b0;
`endif

  always_comb begin
    anode_c = '1;
    if (pwm_on(phase_c, brightness))
      anode_c[idx_p0] = 1'b0;
  end

  // ---- Stage p1: registered pin outputs ----
  logic [NUM_DIGITS-1:0] anode_p1;
  logic [6:0]            seg_p1;
  logic                  dp_n_p1;
  logic                  vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_p1 <= '1;
      seg_p1   <= 7'h7F;
      dp_n_p1  <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      anode_p1 <= anode_c;
      seg_p1   <= blank_c ? 7'h7F : hex_glyph(nib_c);
      dp_n_p1  <= ~shadow_dp_p0[idx_p0];
      vld_p1   <= (cnt_p0 == '0);
    end
  end

  assign anode        = anode_p1;
  assign seg          = seg_p1;
  assign dp_n         = dp_n_p1;
  assign digit_strobe = vld_p1;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux (NUM_DIGITS=4, REFRESH_BITS=4, BRIGHT_BITS=2).
module tb_seg_display_mux;
  localparam int ND = 4;
  localparam int RB = 4;
  localparam int BB = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic        digit_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp_n;
    logic       strobe;
  } obs_t;

  obs_t sb[$];

  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: dwell count, scan index, shadow.
  int          m_cnt = 0;
  int          m_idx = 3;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] FIRST_SEG_ZERO = 7'h7F;
`else
  localparam logic [6:0] FIRST_SEG_ZERO = 7'h40;
`endif

  seg_display_mux #(.NUM_DIGITS(ND), .REFRESH_BITS(RB), .BRIGHT_BITS(BB)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
    .brightness(brightness), .anode(anode), .seg(seg), .dp_n(dp_n),
    .digit_strobe(digit_strobe)
  );

  always #5 clk = ~clk;

  // Push the expected post-edge outputs, advance one clock, pop the expectation.
  task automatic tick(output obs_t exp_o);
    obs_t       e;
    logic       on;
    logic [3:0] nib;
    logic       blank;
    if (reset) begin
      e = '{4'hF, 7'h7F, 1'b1, 1'b0};
      m_cnt = 0; m_idx = 3; m_val = '0; m_dp = '0;
    end else begin
      on = (brightness == 2'd3) || ((m_cnt / 4) < int'(brightness));
      e.anode = on ? ~(4'b0001 << m_idx) : 4'hF;
      nib = m_val[4*m_idx +: 4];
      blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      blank = (m_idx > 0) && ((m_val >> (4*m_idx)) == 16'h0);
`endif
      e.seg    = blank ? 7'h7F : glyph_tbl[nib];
      e.dp_n   = ~m_dp[m_idx];
      e.strobe = (m_cnt == 0);
      if (m_cnt == 15) m_idx = (m_idx == 0) ? 3 : m_idx - 1;
      m_cnt = (m_cnt + 1) % 16;
      if (load) begin m_val = value; m_dp = dp_mask; end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    exp_o = sb.pop_front();
  endtask

  task automatic restart();
    obs_t e;
    reset = 1'b1; load = 1'b0;
    tick(e);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1; load = 1'b1; value = 16'h1234; dp_mask = 4'hF; brightness = 2'd3;
    for (int c = 0; c < 3; c++) begin
      tick(e);
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL reset_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      n_checks++;
      if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got an=%b seg=%h dp=%b st=%b want an=1111 seg=7f dp=1 st=0",
                 c, anode, seg, dp_n, digit_strobe);
      end
    end
    reset = 1'b0; load = 1'b0;
    tick(e);
    n_checks++;
    if ({anode, seg, dp_n, digit_strobe} !== e) begin
      n_fail++;
      $display("FAIL reset_first_sb got %h want %h", {anode, seg, dp_n, digit_strobe}, e);
    end
    n_checks++;
    if (anode !== 4'b0111 || digit_strobe !== 1'b1 || seg !== FIRST_SEG_ZERO || dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first got an=%b st=%b seg=%h dp=%b want an=0111 st=1 seg=%h dp=1",
               anode, digit_strobe, seg, dp_n, FIRST_SEG_ZERO);
    end
  endtask

  task automatic test_frame();
    obs_t       e;
    logic [6:0] want [4];
    int         strobes;
    want = '{7'h79, 7'h08, 7'h30, 7'h0E};
    strobes = 0;
    brightness = 2'd3;
    restart();
    load = 1'b1; value = 16'h1A3F; dp_mask = 4'h0;
    for (int c = 0; c < 64; c++) begin
      tick(e);
      load = 1'b0;
      if (digit_strobe === 1'b1) strobes++;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL frame_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      if (c > 0) begin
        n_checks++;
        if (anode !== ~(4'b1000 >> (c / 16)) || seg !== want[c / 16] ||
            digit_strobe !== (c % 16 == 0)) begin
          n_fail++;
          $display("FAIL frame c=%0d got an=%b seg=%h st=%b want an=%b seg=%h st=%b", c, anode,
                   seg, digit_strobe, ~(4'b1000 >> (c / 16)), want[c / 16], (c % 16 == 0));
        end
      end
    end
    n_checks++;
    if (strobes != 4) begin
      n_fail++;
      $display("FAIL frame_strobes got %0d want 4", strobes);
    end
  endtask

  task automatic test_dp();
    obs_t e;
    brightness = 2'd3;
    restart();
    load = 1'b1; value = 16'h1A3F; dp_mask = 4'b0100;
    for (int c = 0; c < 64; c++) begin
      tick(e);
      load = 1'b0;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL dp_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      n_checks++;
      if (dp_n !== ((anode == 4'b1011) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL dp c=%0d got dp_n=%b an=%b want dp_n=%b", c, dp_n, anode,
                 (anode == 4'b1011) ? 1'b0 : 1'b1);
      end
    end
    dp_mask = 4'h0;
  endtask

  task automatic test_pwm();
    obs_t       e;
    int         lows;
    logic [3:0] want_an;
    lows = 0;
    brightness = 2'd1;
    restart();
    load = 1'b1; value = 16'h1A3F;
    for (int c = 0; c < 64; c++) begin
      tick(e);
      load = 1'b0;
      if (anode !== 4'hF) lows++;
      want_an = (c % 16 < 4) ? ~(4'b1000 >> (c / 16)) : 4'hF;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e || anode !== want_an) begin
        n_fail++;
        $display("FAIL pwm1 c=%0d got %h an=%b want %h an=%b", c,
                 {anode, seg, dp_n, digit_strobe}, anode, e, want_an);
      end
    end
    n_checks++;
    if (lows != 16) begin
      n_fail++;
      $display("FAIL pwm1_lows got %0d want 16", lows);
    end
    brightness = 2'd0;
    restart();
    load = 1'b1; value = 16'h1A3F;
    for (int c = 0; c < 64; c++) begin
      tick(e);
      load = 1'b0;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e || anode !== 4'hF) begin
        n_fail++;
        $display("FAIL pwm0 c=%0d got %h want %h an=1111", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      if (c == 16 || c == 48) begin
        n_checks++;
        if (seg !== ((c == 16) ? 7'h08 : 7'h0E)) begin
          n_fail++;
          $display("FAIL pwm0_seg c=%0d got %h want %h", c, seg, (c == 16) ? 7'h08 : 7'h0E);
        end
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_midload_reset();
    obs_t e;
    brightness = 2'd3;
    restart();
    load = 1'b1; value = 16'h1A3F;
    for (int c = 0; c < 41; c++) begin
      tick(e);
      load = 1'b0;
      reset = 1'b0;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL mid_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      if (c == 20 || c == 21) begin
        n_checks++;
        if (seg !== ((c == 20) ? 7'h08 : 7'h0E)) begin
          n_fail++;
          $display("FAIL mid_load c=%0d got %h want %h", c, seg, (c == 20) ? 7'h08 : 7'h0E);
        end
      end
      if (c >= 21 && c <= 31) begin
        n_checks++;
        if (digit_strobe !== 1'b0 || anode !== 4'b1011) begin
          n_fail++;
          $display("FAIL mid_nostrobe c=%0d got st=%b an=%b want st=0 an=1011", c, digit_strobe, anode);
        end
      end
      if (c == 35) begin
        n_checks++;
        if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_strobe !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_reset got an=%b seg=%h dp=%b st=%b want 1111/7f/1/0", anode, seg, dp_n, digit_strobe);
        end
      end
      if (c == 36) begin
        n_checks++;
        if (anode !== 4'b0111 || digit_strobe !== 1'b1 || seg !== FIRST_SEG_ZERO) begin
          n_fail++;
          $display("FAIL mid_restart got an=%b st=%b seg=%h want 0111/1/%h", anode, digit_strobe, seg, FIRST_SEG_ZERO);
        end
      end
      if (c == 19) begin load = 1'b1; value = 16'hFFFF; end
      if (c == 34) reset = 1'b1;
    end
  endtask

  task automatic test_lz();
    obs_t       e;
    logic [6:0] want_a [4];
    logic [6:0] want_b [4];
`ifdef SEG_LZ_BLANK_EN
    want_a = '{7'h7F, 7'h7F, 7'h19, 7'h40};
    want_b = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    want_a = '{7'h40, 7'h40, 7'h19, 7'h40};
    want_b = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    brightness = 2'd3;
    restart();
    load = 1'b1; value = 16'h0040;
    for (int c = 0; c < 64; c++) begin
      tick(e);
      load = 1'b0;
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL lz40_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      if (c % 16 == 1) begin
        n_checks++;
        if (seg !== want_a[c / 16]) begin
          n_fail++;
          $display("FAIL lz40 c=%0d got %h want %h", c, seg, want_a[c / 16]);
        end
      end
    end
    restart();
    for (int c = 0; c < 64; c++) begin
      tick(e);
      n_checks++;
      if ({anode, seg, dp_n, digit_strobe} !== e) begin
        n_fail++;
        $display("FAIL lz0_sb c=%0d got %h want %h", c, {anode, seg, dp_n, digit_strobe}, e);
      end
      if (c % 16 == 1) begin
        n_checks++;
        if (seg !== want_b[c / 16]) begin
          n_fail++;
          $display("FAIL lz0 c=%0d got %h want %h", c, seg, want_b[c / 16]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_dp();
    test_pwm();
    test_midload_reset();
    test_lz();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
